// File: rtl/refresh_scan_controller.sv
// Multiplexed 4-digit display scan: walks the enabled digits one slot at a time,
// blanking the anodes at the start of every slot to suppress ghosting.
module refresh_scan_controller #(
    parameter int CLK_HZ       = 100_000_000,
    parameter int REFRESH_HZ   = 10_000,
    parameter int BLANK_CYCLES = 100
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] digit_mask,
    output logic [1:0] refreshcounter,
    output logic       blank,
    output logic       digit_tick
);

    localparam int DIV = CLK_HZ / REFRESH_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] BLANK_LAST = PW'(BLANK_CYCLES - 1);
    localparam logic [PW-1:0] SLOT_LAST  = PW'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        SHOW
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [PW-1:0] presc;
    logic [PW-1:0] presc_nx;
    logic [1:0]    rc_nx;
    logic          blank_nx;
    logic          tick_nx;
    logic          run;
    logic          cur_gone;

    function automatic logic [1:0] lowest(input logic [3:0] m);
        lowest = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) lowest = 2'(i);
        end
    endfunction

    // Nearest set bit above cur, wrapping; falls back to cur itself.
    function automatic logic [1:0] next_idx(input logic [1:0] cur,
                                            input logic [3:0] m);
        logic [1:0] c;
        next_idx = cur;
        for (int k = 4; k >= 1; k--) begin
            c = cur + 2'(k);
            if (m[c]) next_idx = c;
        end
    endfunction

    assign run      = enable && (digit_mask != 4'b0000);
    assign cur_gone = !digit_mask[refreshcounter];

    always_ff @(posedge clock) begin
        assert (BLANK_CYCLES >= 1 && BLANK_CYCLES < DIV)
        else $error("BLANK_CYCLES must satisfy 1 <= BLANK_CYCLES < DIV");
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            presc          <= '0;
            refreshcounter <= 2'b00;
            blank          <= 1'b1;
            digit_tick     <= 1'b0;
        end else begin
            state          <= state_nx;
            presc          <= presc_nx;
            refreshcounter <= rc_nx;
            blank          <= blank_nx;
            digit_tick     <= tick_nx;
        end
    end

    always_comb begin
        state_nx = state;
        presc_nx = presc;
        rc_nx    = refreshcounter;
        blank_nx = 1'b1;
        tick_nx  = 1'b0;
        if (!run) begin
            state_nx = IDLE;
            presc_nx = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    state_nx = BLANK;
                    presc_nx = '0;
                    rc_nx    = lowest(digit_mask);
                end
                BLANK: begin
                    presc_nx = presc + 1'b1;
                    if (presc == BLANK_LAST) begin
                        state_nx = SHOW;
                        blank_nx = 1'b0;
                        tick_nx  = 1'b1;
                    end
                end
                SHOW: begin
                    // A cleared current digit cuts its slot short.
                    if (cur_gone || presc == SLOT_LAST) begin
                        state_nx = BLANK;
                        presc_nx = '0;
                        rc_nx    = next_idx(refreshcounter, digit_mask);
                    end else begin
                        presc_nx = presc + 1'b1;
                        blank_nx = 1'b0;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    presc_nx = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_refresh_scan_controller.sv
// Randomized scoreboard bench for refresh_scan_controller against a
// slot-position reference model.
module tb_refresh_scan_controller;

    localparam int CLK_HZ = 100;
    localparam int REF_HZ = 10;
    localparam int BC     = 2;
    localparam int DIV    = CLK_HZ / REF_HZ;

    typedef struct {
        logic [1:0] rc;
        logic       blank;
        logic       tick;
        int         cyc;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [3:0] digit_mask = 4'b0000;
    logic [1:0] refreshcounter;
    logic       blank;
    logic       digit_tick;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;

    bit   m_act = 1'b0;
    int   m_rc = 0;
    int   m_pos = 0;

    refresh_scan_controller #(
        .CLK_HZ      (CLK_HZ),
        .REFRESH_HZ  (REF_HZ),
        .BLANK_CYCLES(BC)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .digit_mask    (digit_mask),
        .refreshcounter(refreshcounter),
        .blank         (blank),
        .digit_tick    (digit_tick)
    );

    always #5 clock = ~clock;

    function automatic int lowest_set(input logic [3:0] m);
        for (int i = 0; i < 4; i++) begin
            if (m[i]) return i;
        end
        return 0;
    endfunction

    function automatic int next_set(input int cur, input logic [3:0] m);
        for (int k = 1; k <= 4; k++) begin
            if (m[(cur + k) % 4]) return (cur + k) % 4;
        end
        return cur;
    endfunction

    // Slot-level model: position within the current DIV-cycle slot.
    task automatic model_edge(input logic r, input logic e,
                              input logic [3:0] m);
        if (r) begin
            m_act = 1'b0;
            m_rc  = 0;
            m_pos = 0;
        end else if (!e || m == 4'b0000) begin
            m_act = 1'b0;
            m_pos = 0;
        end else if (!m_act) begin
            m_act = 1'b1;
            m_rc  = lowest_set(m);
            m_pos = 0;
        end else if ((m_pos >= BC && !m[m_rc]) || m_pos == DIV - 1) begin
            m_rc  = next_set(m_rc, m);
            m_pos = 0;
        end else begin
            m_pos++;
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic [3:0] m);
        exp_t x;
        @(negedge clock);
        reset      = r;
        enable     = e;
        digit_mask = m;
        model_edge(r, e, m);
        x.rc    = 2'(m_rc);
        x.blank = !m_act || m_pos < BC;
        x.tick  = m_act && m_pos == BC;
        x.cyc   = cyc;
        sb.push_back(x);
        cyc++;
    endtask

    task automatic run_until(input logic [3:0] m, input int want_rc,
                             input int want_pos, input string tag);
        for (int n = 0; n < 200; n++) begin
            if (m_act && m_rc == want_rc && m_pos == want_pos) return;
            drive(1'b0, 1'b1, m);
        end
        tests++;
        fails++;
        $display("FAIL %s: target rc=%0d pos=%0d not reached in 200 cycles",
                 tag, want_rc, want_pos);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                tests++;
                if (refreshcounter !== e.rc || blank !== e.blank ||
                    digit_tick !== e.tick) begin
                    fails++;
                    $display("FAIL cyc%0d: got rc=%0d blank=%b tick=%b, want rc=%0d blank=%b tick=%b",
                             e.cyc, refreshcounter, blank, digit_tick,
                             e.rc, e.blank, e.tick);
                end
            end
        end
    end

    initial begin
        logic [3:0] rm;
        logic       rr;
        logic       re;
        repeat (3) drive(1'b1, 1'b0, 4'b0000);
        repeat (2) drive(1'b0, 1'b0, 4'b1111);
        repeat (45) drive(1'b0, 1'b1, 4'b1111);

        run_until(4'b1111, 1, BC + 3, "enable_drop");
        repeat (3) drive(1'b0, 1'b0, 4'b1111);
        repeat (25) drive(1'b0, 1'b1, 4'b1111);

        repeat (40) drive(1'b0, 1'b1, 4'b0101);

        run_until(4'b1111, 2, BC + 4, "mask_cut");
        repeat (20) drive(1'b0, 1'b1, 4'b1011);

        repeat (30) drive(1'b0, 1'b1, 4'b1000);

        run_until(4'b1111, 2, BC + 1, "reset_show");
        repeat (2) drive(1'b1, 1'b1, 4'b1111);
        repeat (20) drive(1'b0, 1'b1, 4'b1111);

        repeat (10) drive(1'b0, 1'b1, 4'b0000);
        repeat (12) drive(1'b0, 1'b0, 4'b0110);

        rm = 4'b1111;
        for (int i = 0; i < 600; i++) begin
            rr = ($urandom_range(0, 99) == 0);
            re = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 19) == 0) rm = 4'($urandom_range(0, 15));
            drive(rr, re, rm);
        end

        @(negedge clock);
        @(negedge clock);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
